// File: rtl/rr_arbiter_ack.sv
// rr_arbiter_ack: registered N-way round-robin/fixed-priority arbiter with request or acknowledge grant hold
module rr_arbiter_ack #(
   parameter int PORTS = 4,
   parameter bit ARB_TYPE_ROUND_ROBIN = 1'b1,
   parameter int BLOCK = 2,
   localparam int W = $clog2(PORTS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] request,
   input  logic [PORTS-1:0] acknowledge,
   output logic [PORTS-1:0] grant,
   output logic             grant_valid,
   output logic [W-1:0]     grant_encoded
);
   logic [W-1:0]     last_idx;
   logic [PORTS-1:0] masked;
   logic [PORTS-1:0] src;
   logic [W-1:0]     pick;
   logic             hold;

   // Pick the next winner: ports after the last grant first, otherwise wrap to the lowest requester
   always_comb begin
      masked = '0;
      for (int i = 0; i < PORTS; i++) masked[i] = request[i] && (W'(i) > last_idx);
      src = (ARB_TYPE_ROUND_ROBIN && |masked) ? masked : request;
      pick = '0;
      for (int i = PORTS - 1; i >= 0; i--) if (src[i]) pick = W'(i);
      hold = (BLOCK == 1) ? (grant_valid && request[grant_encoded]) :
             (BLOCK == 2) ? (grant_valid && !acknowledge[grant_encoded]) : 1'b0;
   end

   // Register the grant unless the current owner is still holding it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant         <= '0;
         grant_valid   <= 1'b0;
         grant_encoded <= '0;
         last_idx      <= W'(PORTS - 1);
      end else if (!hold) begin
         grant         <= (|request) ? ({{(PORTS-1){1'b0}}, 1'b1} << pick) : '0;
         grant_valid   <= |request;
         grant_encoded <= (|request) ? pick : '0;
         if (|request) last_idx <= pick;
      end
   end
endmodule

// File: tb/tb_rr_arbiter_ack.sv
// tb_rr_arbiter_ack: directed tests of the arbiter in each hold policy and in fixed priority
module tb_rr_arbiter_ack;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] request = '0;
   logic [3:0] acknowledge = '0;
   logic [3:0] g0, g1, g2, g3;
   logic       v0, v1, v2, v3;
   logic [1:0] e0, e1, e2, e3;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_arbiter_ack #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b1), .BLOCK(0)) u_b0 (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(g0), .grant_valid(v0), .grant_encoded(e0));
   rr_arbiter_ack #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b1), .BLOCK(1)) u_b1 (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(g1), .grant_valid(v1), .grant_encoded(e1));
   rr_arbiter_ack #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b1), .BLOCK(2)) u_b2 (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(g2), .grant_valid(v2), .grant_encoded(e2));
   rr_arbiter_ack #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b0), .BLOCK(0)) u_fp (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(g3), .grant_valid(v3), .grant_encoded(e3));

   task automatic do_reset(input logic [3:0] req);
      rst = 1'b1;
      request = req;
      acknowledge = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset(4'b0000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({g0, v0, e0} !== 7'b0000_0_00 || {g2, v2, e2} !== 7'b0000_0_00) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: b0=%b b2=%b required 0000_0_00", i, {g0, v0, e0}, {g2, v2, e2});
         end
      end
   endtask

   task automatic test_rotation;
      logic [3:0] exp_g[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [1:0] exp_e[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset(4'b1111);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({g0, v0, e0} !== {exp_g[i], 1'b1, exp_e[i]}) begin
            errors++;
            $display("FAIL rr_rotation step %0d: got %b required %b", i, {g0, v0, e0}, {exp_g[i], 1'b1, exp_e[i]});
         end
      end
   endtask

   task automatic test_ack_hold;
      do_reset(4'b0101);
      @(negedge clk);
      checks++;
      if ({g2, v2, e2} !== 7'b0001_1_00) begin
         errors++;
         $display("FAIL ack_first_grant: got %b required 0001_1_00", {g2, v2, e2});
      end
      request = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({g2, v2, e2} !== 7'b0001_1_00) begin
            errors++;
            $display("FAIL ack_hold_no_req cycle %0d: got %b required 0001_1_00", i, {g2, v2, e2});
         end
      end
      acknowledge = 4'b0010;
      @(negedge clk);
      checks++;
      if ({g2, v2, e2} !== 7'b0001_1_00) begin
         errors++;
         $display("FAIL ack_other_port_ignored: got %b required 0001_1_00", {g2, v2, e2});
      end
      acknowledge = 4'b0001;
      @(negedge clk);
      acknowledge = '0;
      checks++;
      if ({g2, v2, e2} !== 7'b0100_1_10) begin
         errors++;
         $display("FAIL ack_release: got %b required 0100_1_10", {g2, v2, e2});
      end
   endtask

   task automatic test_ack_edge_cases;
      do_reset(4'b0001);
      acknowledge = 4'b0001;
      @(negedge clk);
      acknowledge = '0;
      @(negedge clk);
      checks++;
      if ({g2, v2, e2} !== 7'b0001_1_00) begin
         errors++;
         $display("FAIL ack_before_grant_ignored: got %b required 0001_1_00", {g2, v2, e2});
      end
      request = 4'b1001;
      acknowledge = 4'b0001;
      @(negedge clk);
      checks++;
      if ({g2, v2, e2} !== 7'b1000_1_11) begin
         errors++;
         $display("FAIL ack_back_to_back: got %b required 1000_1_11", {g2, v2, e2});
      end
      acknowledge = 4'b1000;
      request = 4'b1000;
      @(negedge clk);
      checks++;
      if ({g2, v2, e2} !== 7'b1000_1_11) begin
         errors++;
         $display("FAIL sole_regrant: got %b required 1000_1_11", {g2, v2, e2});
      end
      acknowledge = '0;
   endtask

   task automatic test_req_hold;
      do_reset(4'b0011);
      @(negedge clk);
      checks++;
      if ({g1, v1, e1} !== 7'b0001_1_00) begin
         errors++;
         $display("FAIL req_first_grant: got %b required 0001_1_00", {g1, v1, e1});
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({g1, v1, e1} !== 7'b0001_1_00) begin
            errors++;
            $display("FAIL req_hold cycle %0d: got %b required 0001_1_00", i, {g1, v1, e1});
         end
      end
      request = 4'b0010;
      @(negedge clk);
      checks++;
      if ({g1, v1, e1} !== 7'b0010_1_01) begin
         errors++;
         $display("FAIL req_release: got %b required 0010_1_01", {g1, v1, e1});
      end
      request = 4'b0000;
      @(negedge clk);
      checks++;
      if ({g1, v1, e1} !== 7'b0000_0_00) begin
         errors++;
         $display("FAIL req_all_drop: got %b required 0000_0_00", {g1, v1, e1});
      end
   endtask

   task automatic test_fixed;
      do_reset(4'b1010);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({g3, v3, e3} !== 7'b0010_1_01) begin
            errors++;
            $display("FAIL fixed_lowest cycle %0d: got %b required 0010_1_01", i, {g3, v3, e3});
         end
      end
      request = 4'b1000;
      @(negedge clk);
      checks++;
      if ({g3, v3, e3} !== 7'b1000_1_11) begin
         errors++;
         $display("FAIL fixed_single: got %b required 1000_1_11", {g3, v3, e3});
      end
   endtask

   task automatic test_async_reset;
      do_reset(4'b0100);
      @(negedge clk);
      checks++;
      if ({g2, v2, e2} !== 7'b0100_1_10) begin
         errors++;
         $display("FAIL async_pre_grant: got %b required 0100_1_10", {g2, v2, e2});
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({g2, v2, e2} !== 7'b0000_0_00) begin
         errors++;
         $display("FAIL async_reset_immediate: got %b required 0000_0_00", {g2, v2, e2});
      end
      request = 4'b1111;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({g2, v2, e2} !== 7'b0001_1_00) begin
         errors++;
         $display("FAIL async_first_after_reset: got %b required 0001_1_00", {g2, v2, e2});
      end
   endtask

   initial begin
      test_reset;
      test_rotation;
      test_ack_hold;
      test_ack_edge_cases;
      test_req_hold;
      test_fixed;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
